// File: rtl/hc_div16_seq_pkg.sv
// hc_div16_seq_pkg
// Shared definitions for the sequential 16-bit restoring divider:
//   - div_state_t  : controller state encoding (IDLE / CALC / DONE)
//   - HC_DIV_WIDTH : operand, quotient and remainder width
//   - CNT_WIDTH    : width of the iteration counter
package hc_div16_seq_pkg;

   localparam int HC_DIV_WIDTH = 16;
   localparam int CNT_WIDTH    = $clog2(HC_DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

endpackage

// File: rtl/hc_div16_seq_sub17_prefix.sv
// hc_sub17_prefix
// Purely combinational 17-bit subtractor, diff = a - b, built as
// a + ~b + 1 on a parallel-prefix carry network.
// Ports:
//   a         in  17  minuend
//   b         in  17  subtrahend
//   diff      out 17  a - b (modulo 2^17)
//   no_borrow out 1   carry out of the top bit; 1 means a >= b
//
// The carry-in is modelled as an extra prefix position 0 with g=1, p=0,
// so the network spans 18 positions. The tree is a Brent-Kung pairing
// level on odd positions, a sparse Kogge-Stone run over the odd
// positions only, and a final fix-up level that resolves the even ones.
import hc_div16_seq_pkg::*;

module hc_sub17_prefix (
   input  logic [16:0] a,
   input  logic [16:0] b,
   output logic [16:0] diff,
   output logic        no_borrow
);

   localparam int N = 18;

   logic [N-1:0] gs [0:6];
   logic [N-1:0] ps [0:6];

   // Prefix network. After the last level gs[6][i] is the carry out of
   // prefix position i, i.e. the carry into operand bit i.
   always_comb begin
      gs[0] = {a & ~b, 1'b1};
      ps[0] = {a ^ ~b, 1'b0};

      // Brent-Kung up-sweep: each odd position absorbs its even neighbour.
      gs[1] = gs[0];
      ps[1] = ps[0];
      for (int i = 1; i < N; i += 2) begin
         gs[1][i] = gs[0][i] | (ps[0][i] & gs[0][i-1]);
         ps[1][i] = ps[0][i] & ps[0][i-1];
      end

      // Sparse Kogge-Stone over odd positions, distances 2, 4, 8, 16.
      for (int l = 2; l <= 5; l++) begin
         gs[l] = gs[l-1];
         ps[l] = ps[l-1];
         for (int i = 1; i < N; i += 2) begin
            if (i >= (1 << (l-1))) begin
               gs[l][i] = gs[l-1][i] | (ps[l-1][i] & gs[l-1][i - (1 << (l-1))]);
               ps[l][i] = ps[l-1][i] & ps[l-1][i - (1 << (l-1))];
            end
         end
      end

      // Fix-up: even positions take the completed prefix of their odd
      // neighbour below. Position 0 is the carry-in and is already final.
      gs[6] = gs[5];
      ps[6] = ps[5];
      for (int i = 2; i < N; i += 2) begin
         gs[6][i] = gs[5][i] | (ps[5][i] & gs[5][i-1]);
         ps[6][i] = ps[5][i] & ps[5][i-1];
      end
   end

   assign diff      = ps[0][N-1:1] ^ gs[6][N-2:0];
   assign no_borrow = gs[6][N-1];

endmodule

// File: rtl/hc_div16_seq.sv
// hc_div16_seq
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk         in  1   rising-edge clock
//   rst_n       in  1   asynchronous active-low reset
//   in_valid    in  1   request valid
//   in_ready    out 1   request accepted when high (IDLE only)
//   dividend    in  16  sampled on the request handshake
//   divisor     in  16  sampled on the request handshake
//   out_valid   out 1   result valid (DONE only)
//   out_ready   in  1   consumer accepts the result
//   quotient    out 16  result quotient
//   remainder   out 16  result remainder
//   div_by_zero out 1   the divisor of this result was zero
import hc_div16_seq_pkg::*;

module hc_div16_seq (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [HC_DIV_WIDTH-1:0] dividend,
   input  logic [HC_DIV_WIDTH-1:0] divisor,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [HC_DIV_WIDTH-1:0] quotient,
   output logic [HC_DIV_WIDTH-1:0] remainder,
   output logic                    div_by_zero
);

   localparam int WIDTH = HC_DIV_WIDTH;

   div_state_t           state;
   div_state_t           state_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic [WIDTH-1:0]     q;
   logic [WIDTH-1:0]     d;
   logic [WIDTH:0]       r;

   logic [WIDTH:0]       t;
   logic [WIDTH:0]       diff;
   logic                 no_borrow;
   logic [WIDTH:0]       r_next;
   logic [WIDTH-1:0]     q_next;
   logic                 last_iter;
   logic                 accept;
   logic                 divisor_zero;

   // The top bit of r is always zero between iterations; it is kept so the
   // trial value has the full subtractor width, but nothing reads it.
   logic                 unused_r_msb;
   assign unused_r_msb = r[WIDTH];

   assign t            = {r[WIDTH-1:0], q[WIDTH-1]};
   assign last_iter    = (cnt == CNT_WIDTH'(WIDTH-1));
   assign accept       = in_valid && in_ready;
   assign divisor_zero = (divisor == '0);

   hc_sub17_prefix u_sub (
      .a         (t),
      .b         ({1'b0, d}),
      .diff      (diff),
      .no_borrow (no_borrow)
   );

   // Restoring step: keep the difference only when the trial did not borrow.
   assign r_next = no_borrow ? diff : t;
   assign q_next = {q[WIDTH-2:0], no_borrow};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A zero divisor skips the iteration entirely.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = divisor_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs. in_ready is also held low while reset is asserted.
   always_comb begin
      in_ready  = rst_n && (state == IDLE);
      out_valid = (state == DONE);
   end

   // Iteration datapath: operand capture on accept, one shift/subtract per CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         d   <= '0;
         r   <= '0;
         cnt <= '0;
      end else if (accept) begin
         q   <= dividend;
         d   <= divisor;
         r   <= '0;
         cnt <= '0;
      end else if (state == CALC) begin
         q   <= q_next;
         r   <= r_next;
         cnt <= cnt + 1'b1;
      end
   end

   // Result registers: loaded on the way into DONE and held until the next result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept && divisor_zero) begin
         quotient    <= '1;
         remainder   <= dividend;
         div_by_zero <= 1'b1;
      end else if ((state == CALC) && last_iter) begin
         quotient    <= q_next;
         remainder   <= r_next[WIDTH-1:0];
         div_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hc_div16_seq.sv
// tb_hc_div16_seq
// Self-checking bench for hc_div16_seq. Expected results come from plain
// integer division and modulo, with the zero-divisor rule applied directly.
module tb_hc_div16_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks;
   int failures;

   hc_div16_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for in_ready, then present one request for one edge.
   // Returns with time just after the handshake edge T.
   task automatic send_request(input logic [15:0] a, input logic [15:0] b, output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      ok = in_ready;
      if (ok) begin
         dividend = a;
         divisor  = b;
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
      end
   endtask

   // Count edges until out_valid is seen, bounded.
   task automatic wait_valid(output int cycles, output bit timeout);
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         step();
         cycles++;
      end
      timeout = !out_valid;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #12;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || quotient !== 16'h0 ||
          remainder !== 16'h0 || div_by_zero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b q=%h r=%h z=%b, expected 0 0 0000 0000 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_release: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic_100_7;
      bit ok, to;
      int cyc;
      out_ready = 1'b1;
      send_request(16'd100, 16'd7, ok);
      wait_valid(cyc, to);
      checks++;
      if (!ok || to || cyc != 16) begin
         failures++;
         $display("[TB] FAIL latency_100_7: got %0d edges (ok=%b timeout=%b), expected 16", cyc, ok, to);
      end
      checks++;
      if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL result_100_7: got q=%0d r=%0d z=%b, expected 14 2 0", quotient, remainder, div_by_zero);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ready_in_done: got %b, expected 0", in_ready);
      end
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ready_after_result: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_max_operands;
      bit ok, to;
      int cyc;
      logic [15:0] a_tab [2] = '{16'hFFFF, 16'hFFFF};
      logic [15:0] b_tab [2] = '{16'h0001, 16'hFFFF};
      logic [15:0] q_tab [2] = '{16'hFFFF, 16'h0001};
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send_request(a_tab[i], b_tab[i], ok);
         wait_valid(cyc, to);
         checks++;
         if (!ok || to || quotient !== q_tab[i] || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL max_operands_%0d: got q=%h r=%h z=%b to=%b, expected q=%h r=0000 z=0",
                     i, quotient, remainder, div_by_zero, to, q_tab[i]);
         end
         step();
      end
   endtask

   task automatic test_div_by_zero;
      bit ok, to;
      int cyc;
      out_ready = 1'b1;
      send_request(16'd5, 16'd0, ok);
      wait_valid(cyc, to);
      checks++;
      if (!ok || to || cyc != 0) begin
         failures++;
         $display("[TB] FAIL latency_div0: got %0d extra edges (timeout=%b), expected 0", cyc, to);
      end
      checks++;
      if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
         failures++;
         $display("[TB] FAIL result_div0: got q=%h r=%0d z=%b, expected ffff 5 1", quotient, remainder, div_by_zero);
      end
      step();
   endtask

   task automatic test_backpressure;
      bit ok, to;
      int cyc;
      out_ready = 1'b0;
      send_request(16'd3, 16'd10, ok);
      wait_valid(cyc, to);
      checks++;
      if (!ok || to) begin
         failures++;
         $display("[TB] FAIL backpressure_valid: got timeout=%b, expected result", to);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd0 ||
             remainder !== 16'd3 || div_by_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_hold_%0d: got vld=%b rdy=%b q=%0d r=%0d, expected 1 0 0 3",
                     i, out_valid, in_ready, quotient, remainder);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ready_same_cycle: got %b, expected 0", in_ready);
      end
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL backpressure_release: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_calc;
      bit ok, to;
      int cyc;
      bit seen_valid;
      out_ready = 1'b1;
      send_request(16'd40000, 16'd7, ok);
      // Eight iterations later cnt is 8.
      for (int i = 0; i < 8; i++) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid_calc: got vld=%b q=%h r=%h rdy=%b, expected 0 0000 0000 0",
                  out_valid, quotient, remainder, in_ready);
      end
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_discard: got emitted=%b rdy=%b, expected 0 1", seen_valid, in_ready);
      end
      send_request(16'd1000, 16'd33, ok);
      wait_valid(cyc, to);
      checks++;
      if (!ok || to || quotient !== 16'd30 || remainder !== 16'd10 || div_by_zero !== 1'b0) begin
         failures++;
         $display("[TB] FAIL after_reset_1000_33: got q=%0d r=%0d z=%b to=%b, expected 30 10 0",
                  quotient, remainder, div_by_zero, to);
      end
      step();
   endtask

   task automatic test_back_to_back;
      bit ok, got;
      int budget;
      int sel;
      logic [15:0] a, b, exp_q, exp_r;
      logic        exp_z;
      for (int n = 0; n < 2000; n++) begin
         a   = 16'($urandom_range(0, 65535));
         sel = int'($urandom_range(0, 15));
         if (sel == 0)      b = 16'd0;
         else if (sel < 6)  b = 16'($urandom_range(1, 15));
         else               b = 16'($urandom_range(1, 65535));
         if (b == 16'd0) begin
            exp_q = 16'hFFFF;
            exp_r = a;
            exp_z = 1'b1;
         end else begin
            exp_q = a / b;
            exp_r = a % b;
            exp_z = 1'b0;
         end
         send_request(a, b, ok);
         got    = 1'b0;
         budget = 0;
         while (ok && !got && budget < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
               got = 1'b1;
               checks++;
               if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z) begin
                  failures++;
                  $display("[TB] FAIL random_%0d %0d/%0d: got q=%0d r=%0d z=%b, expected q=%0d r=%0d z=%b",
                           n, a, b, quotient, remainder, div_by_zero, exp_q, exp_r, exp_z);
               end
            end
            step();
            budget++;
         end
         if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL random_%0d_timeout: got no result for %0d/%0d, expected one", n, a, b);
            break;
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_100_7();
      test_max_operands();
      test_div_by_zero();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hc_div16_seq.md
# hc_div16_seq

Sequential 16-bit unsigned restoring divider: the inverse operation of the hybrid prefix adders. It produces one quotient bit per clock. Each trial subtraction uses a 17-bit prefix subtractor, built in the same Brent-Kung/Kogge-Stone style as the 16-bit adders with the borrow injected as carry-in. The block sits behind a valid/ready request port and a valid/ready result port, so arithmetic datapaths can offload division without stalling on a combinational path.

## Interface
- WIDTH, 16, operand, quotient and remainder width; the subtractor is WIDTH+1 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- dividend  in  WIDTH  unsigned dividend; sampled on the request handshake.
- divisor  in  WIDTH  unsigned divisor; sampled on the request handshake.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  unsigned quotient.
- remainder  out  WIDTH  unsigned remainder.
- div_by_zero  out  1  the divisor was zero for this result.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: in_ready=1.
  - When in_valid=1, latch the dividend into the quotient shift register q and the divisor into register d, and clear the partial remainder r (WIDTH+1 bits).
  - If divisor=0, go to DONE. Otherwise go to CALC with cnt=0.
- CALC, executed once per cycle:
  - Form t = {r[WIDTH-1:0], q[WIDTH-1]}.
  - Compute diff = t - {1'b0,d} as t + ~{1'b0,d} + 1 through the prefix subtractor; cout=1 means no borrow.
  - On no borrow: r <= diff and q <= {q[WIDTH-2:0],1}.
  - On borrow: r <= t and q <= {q[WIDTH-2:0],0}.
  - cnt increments. After the iteration with cnt=WIDTH-1, go to DONE.
- Divide by zero: quotient = all ones (0xFFFF), remainder = dividend, div_by_zero=1. The subtractor is not used.
- DONE: out_valid=1. quotient, remainder and div_by_zero hold stable until out_ready=1, then return to IDLE.
- No new request is accepted in the same cycle as the result handshake, so in_ready is 0 in that cycle.
- Width rules:
  - r is WIDTH+1 bits so the trial value never overflows.
  - After CALC, r[WIDTH]=0 always holds. remainder = r[WIDTH-1:0] and must be less than the divisor.
- Reset:
  - Reset outputs: in_ready=0 while rst_n=0 and 1 after release; out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - All registers clear asynchronously.
  - Reset in the middle of CALC or DONE discards the operation; nothing is emitted.

## Timing
- Request handshake at edge T, where in_valid & in_ready are both 1.
- Normal divide: CALC occupies cycles T+1 through T+16. out_valid is first high in cycle T+17, giving a latency of WIDTH+1 cycles.
- Divide by zero: out_valid is high in cycle T+1.
- If the result handshake occurs at edge R, in_ready is high from cycle R+1.
- Throughput is one divide per WIDTH+2 cycles when out_ready is held at 1.
- The critical path is a single 17-bit prefix subtractor plus a 2:1 mux into r.

## Structure
- The shared package holds:
  - the FSM state typedef (IDLE/CALC/DONE, 2-bit encoding);
  - the constant HC_DIV_WIDTH=16;
  - the constant for the counter width, $clog2(WIDTH).
- One sub-module, hc_sub17_prefix, a purely combinational subtractor:
  - ports a[16:0], b[16:0], diff[16:0], no_borrow;
  - generate/propagate with g[0]=cin=1 on the inverted b;
  - Brent-Kung up-sweep, then a sparse Kogge-Stone fix-up, matching the adder family.
- The top level holds the FSM, the counter, the q/r/d registers and the output registers.

## Test plan
- 100/7: handshake at T, out_ready=1 → out_valid first high at T+17, quotient=14, remainder=2, div_by_zero=0; in_ready=1 at T+18.
- 0xFFFF/1 → quotient=0xFFFF, remainder=0. Follow with 0xFFFF/0xFFFF → quotient=1, remainder=0.
- 5/0 → out_valid in cycle T+1, quotient=0xFFFF, remainder=5, div_by_zero=1.
- 3/10 with out_ready held 0 for 6 cycles after out_valid → quotient=0, remainder=3 held constant; in_ready stays 0 until one cycle after out_ready=1.
- Assert rst_n=0 when cnt=8 in CALC → out_valid, quotient and remainder are immediately 0. After release, in_ready=1 and a new 1000/33 request returns quotient=30, remainder=10.
- 2000 random operand pairs back-to-back with random out_ready → quotient*divisor+remainder equals dividend and remainder < divisor for every result; divisor=0 cases follow the divide-by-zero rule.
